flag_cond_unit: RTL and testbench
=================================

# flag_cond_unit

Architectural NZVC flags register and condition-code resolver sitting directly downstream of the EX-stage ALU. It captures the ALU's 4-bit NZVC flags when a flag-setting operation completes. It tracks flag-setting operations still in flight and evaluates 4-bit ARM condition codes (B.cond/CSEL) against the correct flags, stalling a request until its producer completes. It delivers a registered branch/select decision to the control path.

## Interface
Parameters:
- CNT_W, 2, width of the in-flight flag-setter counter; max outstanding = 2^CNT_W-1 = 3

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  freeze all state (no register updates)
- flush_i  in  1  squash pending request and all in-flight flag setters
- fs_issue_i  in  1  a flag-setting op enters EX this cycle
- alu_valid_i  in  1  ALU result/flags valid this cycle
- setflags_i  in  1  the completing ALU op sets flags
- flags_i  in  4  ALU flags, bit3 N, bit2 Z, bit1 V, bit0 C
- cond_valid_i  in  1  condition evaluation request
- cond_i  in  4  ARM condition code
- cond_ready_o  out  1  request accepted when cond_valid_i & cond_ready_o
- flags_o  out  4  architectural NZVC register
- br_valid_o  out  1  one-cycle pulse: decision available
- br_taken_o  out  1  condition result (valid with br_valid_o)
- err_o  out  1  sticky counter overflow/underflow

## Operation
- Completion event: cmp = alu_valid_i & setflags_i. On cmp, flags_r <= flags_i regardless of counter.
- Counter cnt: +1 on fs_issue_i, -1 on cmp, unchanged when both occur. fs_issue_i at cnt=3 without cmp: cnt holds at 3, err_o <= 1. cmp at cnt=0: cnt holds at 0, err_o <= 1. err_o is cleared only by rst.
- Condition table (flags N,Z,V,C): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 1.
- FSM: IDLE, WAIT. cond_ready_o = (state==IDLE), combinational.
- IDLE, request accepted:
  - cnt==0: resolve against flags_r.
  - cnt==1 & cmp: resolve against flags_i (bypass).
  - Otherwise: latch cond_i, set wait_cnt = cnt - cmp, go to WAIT.
- Ordering: fs_issue_i in the acceptance cycle or later is younger than the request. It is never waited on: wait_cnt is a snapshot and is not incremented.
- WAIT: each cmp decrements wait_cnt. When cmp occurs with wait_cnt==1, resolve the latched cond against flags_i and return to IDLE.
- Resolve: br_valid_o <= 1 and br_taken_o <= result at the next edge. br_valid_o deasserts after one cycle. br_taken_o holds its last value.
- flush_i (priority over stall_i and all other updates): state <= IDLE, cnt <= 0, wait_cnt <= 0, br_valid_o <= 0. A resolve in the same cycle is discarded. flags_r still captures a same-cycle cmp. err_o is unchanged.
- stall_i (without flush): all registers hold, including flags_r, cnt, state, br_valid_o and br_taken_o. Inputs are ignored. cond_ready_o still reflects state, but no acceptance occurs.

## Timing
- Reset values: flags_o=4'b0000, br_valid_o=0, br_taken_o=0, err_o=0, state=IDLE (cond_ready_o=1), cnt=0, wait_cnt=0.
- Resolve latency: 1 cycle from acceptance (no dependency) or from the final completion (WAIT) to br_valid_o.
- flags_o reflects cmp one cycle after the completing edge.
- Bypass path is combinational from flags_i to br_taken_o's D input.
- Reset mid-WAIT aborts the request. No br_valid_o is produced.

## Test plan
- Reset, then request cond=0000 with cnt=0 and flags_r=0100 -> br_valid_o=1, br_taken_o=1 one cycle later; cond_ready_o stays 1.
- Issue one flag setter, then request cond=1011 (LT) -> cond_ready_o=0 (WAIT). Two cycles later, cmp with flags_i=1000 (N=1, V=0) -> br_valid_o=1, br_taken_o=1 next cycle; flags_o=1000.
- cnt=1, request in the same cycle as cmp with flags_i=0001, cond=1000 (HI) -> bypass, br_taken_o=1 next cycle, no WAIT entry.
- cnt=2, request accepted, then fs_issue_i in the next cycle (younger), then two cmps -> resolves after the 2nd cmp, not the 3rd; cnt=1 afterwards.
- In WAIT, assert flush_i -> next cycle state=IDLE, cnt=0, br_valid_o never pulses; a subsequent cond=1110 resolves taken in 1 cycle.
- Four fs_issue_i with no completions -> cnt=3, err_o=1 sticky. A cmp at cnt=0 after rst also gives err_o=1.

Source files
------------

// File: rtl/flag_cond_unit.sv
// NZVC flags register with an ARM condition-code resolver.
// Requests wait for older in-flight flag setters before resolving.
module flag_cond_unit #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic       fs_issue_i,
    input  logic       alu_valid_i,
    input  logic       setflags_i,
    input  logic [3:0] flags_i,
    input  logic       cond_valid_i,
    input  logic [3:0] cond_i,
    output logic       cond_ready_o,
    output logic [3:0] flags_o,
    output logic       br_valid_o,
    output logic       br_taken_o,
    output logic       err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, wait_cnt, wait_cnt_nxt;
    logic [3:0]       flags_r, cond_r, cond_nxt;
    logic             cmp, resolve, result, err_nxt;

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, r;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cy;
            4'b0011: r = !cy;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cy & !z;
            4'b1001: r = !cy | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign flags_o = flags_r;

    always_comb begin
        cmp          = alu_valid_i & setflags_i;
        cond_ready_o = (state == IDLE);
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        cond_nxt     = cond_r;
        resolve      = 1'b0;
        result       = 1'b0;
        cnt_nxt      = cnt;
        err_nxt      = err_o;
        case (state)
            IDLE: begin
                if (cond_valid_i) begin
                    if (cnt == CNT_ZERO) begin
                        resolve = 1'b1;
                        result  = eval_cond(cond_i, flags_r);
                    end else if (cnt == CNT_ONE && cmp) begin
                        resolve = 1'b1;
                        result  = eval_cond(cond_i, flags_i);
                    end else begin
                        // Snapshot of older setters only; younger issues never join it
                        cond_nxt     = cond_i;
                        wait_cnt_nxt = cnt - {{(CNT_W-1){1'b0}}, cmp};
                        state_nxt    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cmp) begin
                    if (wait_cnt == CNT_ONE) begin
                        resolve      = 1'b1;
                        result       = eval_cond(cond_r, flags_i);
                        state_nxt    = IDLE;
                        wait_cnt_nxt = CNT_ZERO;
                    end else begin
                        wait_cnt_nxt = wait_cnt - CNT_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (fs_issue_i && !cmp) begin
            if (cnt == CNT_MAX) err_nxt = 1'b1;
            else                cnt_nxt = cnt + CNT_ONE;
        end else if (cmp && !fs_issue_i) begin
            if (cnt == CNT_ZERO) err_nxt = 1'b1;
            else                 cnt_nxt = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= CNT_ZERO;
            wait_cnt   <= CNT_ZERO;
            cond_r     <= 4'b0000;
            flags_r    <= 4'b0000;
            br_valid_o <= 1'b0;
            br_taken_o <= 1'b0;
            err_o      <= 1'b0;
        end else if (flush_i) begin
            state      <= IDLE;
            cnt        <= CNT_ZERO;
            wait_cnt   <= CNT_ZERO;
            br_valid_o <= 1'b0;
            if (cmp) flags_r <= flags_i;
        end else if (!stall_i) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            cond_r     <= cond_nxt;
            err_o      <= err_nxt;
            br_valid_o <= resolve;
            if (resolve) br_taken_o <= result;
            if (cmp)     flags_r    <= flags_i;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed scenarios plus random
// stimulus, all compared against a behavioural model of the flags unit.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall_i, flush_i, fs_issue_i, alu_valid_i, setflags_i, cond_valid_i;
    logic [3:0] flags_i, cond_i;
    logic       cond_ready_o, br_valid_o, br_taken_o, err_o;
    logic [3:0] flags_o;

    int errors = 0;
    int checks = 0;

    // Model state: m_wait is the number of older setters still owed (0 = idle)
    bit [3:0] m_flags, m_cond;
    int       m_cnt, m_wait;
    bit       m_err, m_bv, m_bt;

    flag_cond_unit #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .fs_issue_i(fs_issue_i), .alu_valid_i(alu_valid_i), .setflags_i(setflags_i),
        .flags_i(flags_i), .cond_valid_i(cond_valid_i), .cond_i(cond_i),
        .cond_ready_o(cond_ready_o), .flags_o(flags_o), .br_valid_o(br_valid_o),
        .br_taken_o(br_taken_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ARM rule: bits [3:1] pick a base test, bit 0 inverts it (except AL/NV)
    function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
        bit n, z, v, cy, base;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) return !base;
        return base;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("flags_o", {4'b0, flags_o}, {4'b0, m_flags});
        checkOutput("br_valid_o", {7'b0, br_valid_o}, {7'b0, m_bv});
        if (m_bv) checkOutput("br_taken_o", {7'b0, br_taken_o}, {7'b0, m_bt});
        checkOutput("err_o", {7'b0, err_o}, {7'b0, m_err});
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        {stall_i, flush_i, fs_issue_i, alu_valid_i, setflags_i, cond_valid_i} = '0;
        flags_i = 4'b0; cond_i = 4'b0;
        #12;
        @(negedge clk);
        rst = 1'b0;
        m_flags = 0; m_cond = 0; m_cnt = 0; m_wait = 0; m_err = 0; m_bv = 0; m_bt = 0;
        checkAll();
        checkOutput("br_taken_rst", {7'b0, br_taken_o}, 8'd0);
        checkOutput("cond_ready_rst", {7'b0, cond_ready_o}, 8'd1);
    endtask

    task automatic applyStimulus(input bit st, input bit fl, input bit is, input bit av,
                                 input bit sf, input bit [3:0] fi, input bit cv,
                                 input bit [3:0] cc);
        bit cmp, rv, rt;
        @(negedge clk);
        stall_i = st; flush_i = fl; fs_issue_i = is; alu_valid_i = av;
        setflags_i = sf; flags_i = fi; cond_valid_i = cv; cond_i = cc;
        #1;
        checkOutput("cond_ready_o", {7'b0, cond_ready_o}, {7'b0, (m_wait == 0)});
        cmp = av && sf;
        rv = 1'b0;
        rt = 1'b0;
        if (fl) begin
            if (cmp) m_flags = fi;
            m_cnt = 0; m_wait = 0; m_bv = 0;
        end else if (!st) begin
            if (m_wait == 0) begin
                if (cv) begin
                    if (m_cnt == 0) begin
                        rv = 1; rt = ref_cond(cc, m_flags);
                    end else if (m_cnt == 1 && cmp) begin
                        rv = 1; rt = ref_cond(cc, fi);
                    end else begin
                        m_wait = m_cnt - int'(cmp);
                        m_cond = cc;
                    end
                end
            end else if (cmp) begin
                if (m_wait == 1) begin
                    rv = 1; rt = ref_cond(m_cond, fi); m_wait = 0;
                end else begin
                    m_wait--;
                end
            end
            if (is && !cmp) begin
                if (m_cnt == 3) m_err = 1; else m_cnt++;
            end else if (cmp && !is) begin
                if (m_cnt == 0) m_err = 1; else m_cnt--;
            end
            if (cmp) m_flags = fi;
            m_bv = rv;
            if (rv) m_bt = rt;
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        doReset();

        // Request with no producer in flight resolves from the flags register
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 1, 1, 4'b0100, 0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 4'b0000);
        checkOutput("eq_taken", {7'b0, br_taken_o}, 8'd1);
        checkOutput("eq_ready", {7'b0, cond_ready_o}, 8'd1);

        // LT waits for its producer
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 4'b1011);
        idle();
        idle();
        applyStimulus(0, 0, 0, 1, 1, 4'b1000, 0, 4'h0);
        checkOutput("lt_taken", {7'b0, br_taken_o}, 8'd1);
        checkOutput("lt_flags", {4'b0, flags_o}, 8'h08);

        // Bypass: request alongside the only outstanding completion
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 1, 1, 4'b0001, 1, 4'b1000);
        checkOutput("hi_bypass", {7'b0, br_taken_o}, 8'd1);
        checkOutput("hi_no_wait", {7'b0, cond_ready_o}, 8'd1);

        // Younger issue after acceptance is not waited on
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 1, 1, 4'b0010, 0, 4'h0);
        applyStimulus(0, 0, 0, 1, 1, 4'b0011, 0, 4'h0);
        checkOutput("young_resolved", {7'b0, br_valid_o}, 8'd1);
        applyStimulus(0, 0, 0, 1, 1, 4'b0000, 0, 4'h0);

        // Flush in WAIT, then an AL resolves immediately
        applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 4'b0000);
        applyStimulus(0, 1, 0, 0, 0, 4'h0, 0, 4'h0);
        checkOutput("flush_ready", {7'b0, cond_ready_o}, 8'd1);
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 4'b1110);
        checkOutput("al_taken", {7'b0, br_taken_o}, 8'd1);

        // Overflow, then underflow after reset
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 4'h0, 0, 4'h0);
        idle();
        checkOutput("overflow_err", {7'b0, err_o}, 8'd1);
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 4'h5, 0, 4'h0);
        checkOutput("underflow_err", {7'b0, err_o}, 8'd1);

        // Random traffic, with occasional resets to clear the sticky error
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) doReset();
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 7, 4'($urandom),
                          $urandom_range(0, 9) < 4, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
